// File: rtl/vend_ctrl.sv
// Vending controller: accumulates Q/D/N credit toward PRICE, strobes item_release
// ("release" is a reserved word), then pays change one coin per ready/valid handshake.
// Optional refund-on-cancel is enabled by defining VEND_CANCEL_EN.
module vend_ctrl #(
    parameter int unsigned PRICE    = 30,
    parameter int unsigned CREDIT_W = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_q,
    input  logic                coin_d,
    input  logic                coin_n,
    input  logic                cancel,
    output logic                item_release,
    output logic                coin_reject,
    output logic                chg_valid,
    output logic [1:0]          chg_coin,
    input  logic                chg_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_VEND    = 2'd1,
        ST_CHANGE  = 2'd2
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ZERO_C    = {CREDIT_W{1'b0}};
    localparam logic [1:0]          COIN_NONE = 2'b00;
    localparam logic [1:0]          COIN_N    = 2'b01;
    localparam logic [1:0]          COIN_D    = 2'b10;
    localparam logic [1:0]          COIN_Q    = 2'b11;

    function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] amt);
        if (amt >= CREDIT_W'(25)) begin
            return COIN_Q;
        end else if (amt >= CREDIT_W'(10)) begin
            return COIN_D;
        end else begin
            return COIN_N;
        end
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] c);
        case (c)
            COIN_Q:  return CREDIT_W'(25);
            COIN_D:  return CREDIT_W'(10);
            COIN_N:  return CREDIT_W'(5);
            default: return ZERO_C;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_left_q, change_left_d;
    logic                release_q, release_d;
    logic                reject_q, reject_d;
    logic                chg_valid_q, chg_valid_d;
    logic [1:0]          chg_coin_q, chg_coin_d;
    logic                busy_q, busy_d;
    logic [1:0]          coin_cnt_s;
    logic [CREDIT_W-1:0] coin_add_s;
    logic [CREDIT_W-1:0] sum_s;
    logic                cancel_req_s;

    // Next-state, credit/change arithmetic and registered-output decode
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        change_left_d = change_left_q;
        release_d     = 1'b0;
        reject_d      = 1'b0;
        coin_cnt_s    = {1'b0, coin_q} + {1'b0, coin_d} + {1'b0, coin_n};
        if (coin_q) begin
            coin_add_s = CREDIT_W'(25);
        end else if (coin_d) begin
            coin_add_s = CREDIT_W'(10);
        end else if (coin_n) begin
            coin_add_s = CREDIT_W'(5);
        end else begin
            coin_add_s = ZERO_C;
        end
        sum_s = credit_q + coin_add_s;
`ifdef VEND_CANCEL_EN
        cancel_req_s = cancel && (credit_q != ZERO_C);
`else
        cancel_req_s = cancel & 1'b0;
`endif
        case (state_q)
            ST_COLLECT: begin
                if (cancel_req_s) begin
                    // Refund wins over any coin arriving in the same cycle
                    change_left_d = credit_q;
                    credit_d      = ZERO_C;
                    state_d       = ST_CHANGE;
                    reject_d      = (coin_cnt_s != 2'd0);
                end else if (sum_s >= PRICE_C) begin
                    change_left_d = sum_s - PRICE_C;
                    credit_d      = ZERO_C;
                    state_d       = ST_VEND;
                    release_d     = 1'b1;
                    reject_d      = (coin_cnt_s > 2'd1);
                end else begin
                    credit_d      = sum_s;
                    reject_d      = (coin_cnt_s > 2'd1);
                end
            end
            ST_VEND: begin
                reject_d = (coin_cnt_s != 2'd0);
                if (change_left_q != ZERO_C) begin
                    state_d = ST_CHANGE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_CHANGE: begin
                reject_d = (coin_cnt_s != 2'd0);
                if (chg_valid_q && chg_ready) begin
                    change_left_d = change_left_q - coin_value(chg_coin_q);
                    if (change_left_d == ZERO_C) begin
                        state_d = ST_COLLECT;
                    end else begin
                        state_d = ST_CHANGE;
                    end
                end else begin
                    change_left_d = change_left_q;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
        chg_valid_d = (state_d == ST_CHANGE);
        if (chg_valid_d) begin
            chg_coin_d = greedy_coin(change_left_d);
        end else begin
            chg_coin_d = COIN_NONE;
        end
        busy_d = (state_d != ST_COLLECT);
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_COLLECT;
            credit_q      <= ZERO_C;
            change_left_q <= ZERO_C;
            release_q     <= 1'b0;
            reject_q      <= 1'b0;
            chg_valid_q   <= 1'b0;
            chg_coin_q    <= COIN_NONE;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            change_left_q <= change_left_d;
            release_q     <= release_d;
            reject_q      <= reject_d;
            chg_valid_q   <= chg_valid_d;
            chg_coin_q    <= chg_coin_d;
            busy_q        <= busy_d;
        end
    end

    assign item_release = release_q;
    assign coin_reject  = reject_q;
    assign chg_valid    = chg_valid_q;
    assign chg_coin     = chg_coin_q;
    assign credit       = credit_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl (PRICE=30): vector table applied through a
// scoreboard queue, plus hand-written multi-cycle sequences.
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_q, coin_d, coin_n, cancel, chg_ready;
    logic       item_release, coin_reject, chg_valid, busy;
    logic [1:0] chg_coin;
    logic [6:0] credit;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    typedef struct {
        logic       rst, q, d, n, c, rdy;
        logic       rel, rej, vld;
        logic [1:0] coin;
        logic [6:0] cred;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    vend_ctrl #(.PRICE(30), .CREDIT_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .coin_q(coin_q), .coin_d(coin_d), .coin_n(coin_n),
        .cancel(cancel), .item_release(item_release), .coin_reject(coin_reject),
        .chg_valid(chg_valid), .chg_coin(chg_coin), .chg_ready(chg_ready),
        .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int rst, input int q, input int d, input int n,
                                input int c, input int rdy, input int rel, input int rej,
                                input int vld, input int coin, input int cred, input int bsy);
        vec_t v;
        v.rst = rst[0]; v.q = q[0]; v.d = d[0]; v.n = n[0]; v.c = c[0]; v.rdy = rdy[0];
        v.rel = rel[0]; v.rej = rej[0]; v.vld = vld[0]; v.coin = coin[1:0];
        v.cred = cred[6:0]; v.busy = bsy[0];
        return v;
    endfunction

    task automatic check(input string name, input int got, input int want);
        tot_cnt++;
        if (got == want) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic drive(input int q, input int d, input int n, input int c, input int rdy);
        coin_q = q[0]; coin_d = d[0]; coin_n = n[0]; cancel = c[0]; chg_ready = rdy[0];
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        rst_n = ~v.rst;
        coin_q = v.q; coin_d = v.d; coin_n = v.n; cancel = v.c; chg_ready = v.rdy;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("v%0d.release", idx), int'(item_release), int'(e.rel));
        check($sformatf("v%0d.coin_reject", idx), int'(coin_reject), int'(e.rej));
        check($sformatf("v%0d.chg_valid", idx), int'(chg_valid), int'(e.vld));
        check($sformatf("v%0d.chg_coin", idx), int'(chg_coin), int'(e.coin));
        check($sformatf("v%0d.credit", idx), int'(credit), int'(e.cred));
        check($sformatf("v%0d.busy", idx), int'(busy), int'(e.busy));
    endtask

    initial begin
        int accepted;
        int cycles;
        bit done;
        rst_n = 1'b0;
        coin_q = 1'b0; coin_d = 1'b0; coin_n = 1'b0; cancel = 1'b0; chg_ready = 1'b0;

        //              rst q d n c rdy  rel rej vld coin cred busy
        vecs.push_back(mk(1, 0,0,0,0,0,   0,0,0,0, 0,0));   // reset state
        // quarter + nickel: exact price, no change
        vecs.push_back(mk(0, 1,0,0,0,0,   0,0,0,0, 25,0));
        vecs.push_back(mk(0, 0,0,1,0,0,   1,0,0,0, 0,1));
        vecs.push_back(mk(0, 0,0,0,0,0,   0,0,0,0, 0,0));
        // two quarters, ready held high: two dimes back
        vecs.push_back(mk(0, 1,0,0,0,0,   0,0,0,0, 25,0));
        vecs.push_back(mk(0, 1,0,0,0,1,   1,0,0,0, 0,1));
        vecs.push_back(mk(0, 0,0,0,0,1,   0,0,1,2, 0,1));
        vecs.push_back(mk(0, 0,0,0,0,1,   0,0,1,2, 0,1));
        vecs.push_back(mk(0, 0,0,0,0,1,   0,0,0,0, 0,0));
        vecs.push_back(mk(0, 0,0,0,0,1,   0,0,0,0, 0,0));   // stray ready ignored
        // five nickels, a quarter, dispenser stalls three cycles
        for (int i = 1; i <= 5; i++) vecs.push_back(mk(0, 0,0,1,0,0, 0,0,0,0, 5*i,0));
        vecs.push_back(mk(0, 1,0,0,0,0,   1,0,0,0, 0,1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0,0,0,0,0, 0,0,1,2, 0,1));
        vecs.push_back(mk(0, 0,0,0,0,1,   0,0,1,2, 0,1));
        vecs.push_back(mk(0, 0,0,0,0,1,   0,0,0,0, 0,0));
        // simultaneous coins, then a coin during CHANGE
        vecs.push_back(mk(0, 1,1,0,0,0,   0,1,0,0, 25,0));
        vecs.push_back(mk(0, 0,0,0,0,0,   0,0,0,0, 25,0));
        vecs.push_back(mk(0, 0,1,0,0,0,   1,0,0,0, 0,1));
        vecs.push_back(mk(0, 0,0,0,0,0,   0,0,1,1, 0,1));
        vecs.push_back(mk(0, 0,0,1,0,0,   0,1,1,1, 0,1));
        vecs.push_back(mk(0, 0,0,0,0,1,   0,0,0,0, 0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,   0,0,0,0, 0,0));
        // reset mid-CHANGE with 20 cents pending, then a dime
        vecs.push_back(mk(0, 1,0,0,0,0,   0,0,0,0, 25,0));
        vecs.push_back(mk(0, 1,0,0,0,0,   1,0,0,0, 0,1));
        vecs.push_back(mk(0, 0,0,0,0,0,   0,0,1,2, 0,1));
        vecs.push_back(mk(1, 0,0,0,0,0,   0,0,0,0, 0,0));
        vecs.push_back(mk(0, 0,1,0,0,0,   0,0,0,0, 10,0));
        vecs.push_back(mk(0, 0,0,0,0,1,   0,0,0,0, 10,0));
        vecs.push_back(mk(1, 0,0,0,0,0,   0,0,0,0, 0,0));
        // cancel handling
        vecs.push_back(mk(0, 1,0,0,0,0,   0,0,0,0, 25,0));
`ifdef VEND_CANCEL_EN
        vecs.push_back(mk(0, 0,0,1,1,0,   0,1,1,3, 0,1));
        vecs.push_back(mk(0, 0,0,0,0,1,   0,0,0,0, 0,0));
        vecs.push_back(mk(0, 0,0,1,0,0,   0,0,0,0, 5,0));
        vecs.push_back(mk(0, 0,0,0,1,1,   0,0,1,1, 0,1));
        vecs.push_back(mk(0, 0,0,0,0,1,   0,0,0,0, 0,0));
        vecs.push_back(mk(0, 0,0,0,1,0,   0,0,0,0, 0,0));
`else
        vecs.push_back(mk(0, 0,0,1,1,0,   1,0,0,0, 0,1));
        vecs.push_back(mk(0, 0,0,0,0,1,   0,0,0,0, 0,0));
        vecs.push_back(mk(0, 0,0,1,0,0,   0,0,0,0, 5,0));
        vecs.push_back(mk(0, 0,0,0,1,1,   0,0,0,0, 5,0));
        vecs.push_back(mk(0, 0,0,0,0,1,   0,0,0,0, 5,0));
        vecs.push_back(mk(0, 0,0,0,1,0,   0,0,0,0, 5,0));
`endif

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Three dimes: release right after the third, nothing to pay back
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        check("hw.reset_credit", int'(credit), 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        check("hw.credit_20", int'(credit), 20);
        drive(0, 1, 0, 0, 0);
        check("hw.release_3d", int'(item_release), 1);
        drive(0, 0, 0, 0, 1);
        check("hw.no_change_valid", int'(chg_valid), 0);
        check("hw.idle_busy", int'(busy), 0);

        // Two quarters with a randomly stalling dispenser: exactly two dimes
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check("hw.release_2q", int'(item_release), 1);
        accepted = 0;
        cycles = 0;
        done = 1'b0;
        while (!done && cycles < 40) begin
            coin_q = 1'b0; coin_d = 1'b0; coin_n = 1'b0; cancel = 1'b0;
            chg_ready = 1'($urandom_range(0, 1));
            if (chg_valid && chg_ready) begin
                accepted++;
                check("hw.stall_coin", int'(chg_coin), 2);
            end
            @(posedge clk);
            #1;
            cycles++;
            if (!busy) done = 1'b1;
        end
        check("hw.stall_done", int'(done), 1);
        check("hw.stall_accepted", accepted, 2);
        check("hw.stall_credit", int'(credit), 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
